// File: rtl/conv_pe_mac.sv
// conv_pe_mac: streaming multi-lane convolution MAC with bias, ReLU and quantisation.
// Define CONV_PE_SAT_EN to clamp the quantised result instead of wrapping it.
module conv_pe_mac #(
    parameter int DW    = 16,
    parameter int LANES = 2,
    parameter int BW    = 32,
    parameter int ACCW  = 40,
    parameter int SCALE = 1000,
    parameter int RELU  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [LANES*DW-1:0]    x,
    input  logic [LANES*DW-1:0]    w,
    input  logic [BW-1:0]          b,
    output logic [DW-1:0]          odata,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam logic [1:0] ACC     = 2'd0;
    localparam logic [1:0] RELU_S  = 2'd1;
    localparam logic [1:0] QUANT_S = 2'd2;
    localparam logic [1:0] OUT     = 2'd3;

    localparam logic signed [ACCW-1:0] SCALE_C = ACCW'(SCALE);

`ifdef CONV_PE_SAT_EN
    localparam logic signed [ACCW-1:0] QMAX = ACCW'({1'b0, {(DW-1){1'b1}}});
    localparam logic signed [ACCW-1:0] QMIN = ~QMAX;
`endif

    logic [1:0]             state_q, state_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [ACCW-1:0] r_q, r_d;
    logic                   first_q, first_d;
    logic [DW-1:0]          odata_q, odata_d;

    logic signed [ACCW-1:0] sum;
    logic signed [ACCW-1:0] base;
    logic signed [ACCW-1:0] q;
    logic                   accept;
    logic                   out_hs;

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == OUT);
    assign odata     = odata_q;
    assign accept    = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    // Sum of full-width signed lane products, sign-extended to the accumulator
    always_comb begin
        logic signed [2*DW-1:0] prod;
        sum  = '0;
        prod = '0;
        for (int i = 0; i < LANES; i++) begin
            prod = $signed(x[i*DW +: DW]) * $signed(w[i*DW +: DW]);
            sum  = sum + ACCW'(prod);
        end
    end

    // Bias seeds the first beat; later beats build on the running sum
    assign base = first_q ? ACCW'($signed(b)) : acc_q;

    // Signed division truncates toward zero
    assign q = r_q / SCALE_C;

    // Next-state logic for the accumulate / activate / quantise / output sequence
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        r_d     = r_q;
        first_d = first_q;
        odata_d = odata_q;
        unique case (state_q)
            ACC: begin
                if (accept) begin
                    acc_d   = base + sum;
                    first_d = 1'b0;
                    if (in_last) begin
                        state_d = RELU_S;
                    end
                end
            end
            RELU_S: begin
                if ((RELU != 0) && (acc_q < 0)) begin
                    r_d = '0;
                end else begin
                    r_d = acc_q;
                end
                state_d = QUANT_S;
            end
            QUANT_S: begin
`ifdef CONV_PE_SAT_EN
                if (q > QMAX) begin
                    odata_d = QMAX[DW-1:0];
                end else if (q < QMIN) begin
                    odata_d = QMIN[DW-1:0];
                end else begin
                    odata_d = q[DW-1:0];
                end
`else
                odata_d = q[DW-1:0];
`endif
                state_d = OUT;
            end
            OUT: begin
                if (out_hs) begin
                    first_d = 1'b1;
                    state_d = ACC;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    // State registers; reset discards any partial sum or pending result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ACC;
            acc_q   <= '0;
            r_q     <= '0;
            first_q <= 1'b1;
            odata_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            r_q     <= r_d;
            first_q <= first_d;
            odata_q <= odata_d;
        end
    end

endmodule

// File: doc/conv_pe_mac.md
# conv_pe_mac

Parametrised convolution processing element for the CFNP conv layers. It accepts a kernel as a stream of `LANES`-wide beats of activations and weights, and multiply-accumulates them onto a bias. It then applies optional ReLU and scale-down quantisation, and returns one `DW`-bit result through a valid/ready handshake. Compared with the fixed two-tap conv1 element, it adds arbitrary kernel length (any number of beats), lane count, width, a linear/ReLU mode, input/output backpressure and optional saturation.

## Interface
- `DW`, 16: signed width of activations, weights and `odata`.
- `LANES`, 2: multipliers per beat.
- `BW`, 32: signed bias width.
- `ACCW`, 40: signed accumulator width.
- `SCALE`, 1000: positive quantisation divisor.
- `RELU`, 1: 1 applies ReLU; 0 passes values through linearly.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  beat present.
- `in_ready`  out  1  PE accepts a beat.
- `in_last`  in  1  final beat of the kernel.
- `x`  in  `LANES*DW`  packed signed activations; lane i is bits [i*DW +: DW].
- `w`  in  `LANES*DW`  packed signed weights, same packing as `x`.
- `b`  in  `BW`  signed bias; sampled on the first beat of a kernel only.
- `odata`  out  `DW`  signed result.
- `out_valid`  out  1  `odata` valid.
- `out_ready`  in  1  consumer accepts the result.

## Operation
- States:
  - `ACC`: reset state; `in_ready`=1.
  - `RELU_S`
  - `QUANT_S`
  - `OUT`: `out_valid`=1.
- Accept occurs when `in_valid && in_ready`.
  - On each accept: `acc <= (first ? sext(b) : acc) + Σ sext(x_i*w_i)`.
  - `first` is set at reset and after every output handshake, and cleared on any accept.
- Products are full 2·DW signed values, sign-extended to `ACCW`. Accumulator overflow wraps modulo 2^ACCW and is not detected.
- On an accept with `in_last`=1, go to `RELU_S`.
- `RELU_S`: `r <= (RELU && acc<0) ? 0 : acc`. Next state is `QUANT_S`.
- `QUANT_S`: `q = r / SCALE`, signed, truncated toward zero. `odata <=` narrowed q (see Configuration). Next state is `OUT`.
- `OUT`: hold `odata` stable until `out_ready`=1. Then return to `ACC` with `first`=1.
- A single-beat kernel (`in_last` on the first beat) is legal.
- `in_valid` is ignored outside `ACC`.
- Unused high lanes are zeroed by the driver; the PE applies no masking.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `odata`=0, `acc`=0, `r`=0, `first`=1. The state returns to `ACC` immediately and asynchronously.
- Throughput: one beat per cycle while in `ACC`. A kernel of N beats occupies N cycles.
- Latency: `out_valid` rises 2 clock edges after the edge that accepts the last beat.
- `in_ready` falls on the edge after the last-beat accept. It rises on the edge where the output handshake completes, so the earliest next-kernel beat is accepted 1 cycle after `out_ready`.
- Minimum period between results is N+3 cycles.
- Under backpressure (`out_ready`=0), `odata` and `out_valid` hold indefinitely.
- Reset asserted mid-kernel or during `OUT` discards the partial sum and any pending result. No output is produced for that kernel.
- `in_valid` may drop between beats. The accumulator holds its value and `first` is unaffected.

## Configuration
- `CONV_PE_SAT_EN` defined: q is clamped to [-2^(DW-1), 2^(DW-1)-1].
- `CONV_PE_SAT_EN` undefined: `odata` is the low `DW` bits of q (wrap, conv1-compatible).

## Test plan
Defaults for all scenarios: `DW`=16, `LANES`=2, `SCALE`=1000.

1. Single beat, `x`=(100,200), `w`=(3,4), `b`=1000, `in_last`=1 → `odata`=2, with `out_valid` 2 edges after accept.
2. `RELU`=1, `x`=(100,0), `w`=(-50,0), `b`=0 → `odata`=0. Rebuild with `RELU`=0 → `odata`=-5.
3. Three beats (1,1)·(1000,1000) each, `b`=0, with one idle cycle between beats 2 and 3 → `odata`=6.
   - `in_ready` is low after the last beat.
4. `out_ready` held low for 5 cycles after `out_valid` → `odata` stable and `in_ready`=0 throughout.
   - Handshake then completes; the next kernel is accepted 1 cycle after `out_ready`.
   - `first` reloads `b` (no carry-over).
5. `x`=(32767,32767), `w`=(32767,32767), `b`=0:
   - With `CONV_PE_SAT_EN` → `odata`=32767.
   - Without → `odata`=-15336 (low 16 bits of 2147352).
6. Assert `rst` low after beat 2 of a 3-beat kernel → `out_valid`=0, `odata`=0, `in_ready`=1 immediately.
   - After release, a new kernel computes from `b` only.
